// File: rtl/cipher_seq_ctrl.sv
// Serial key/message loader with chunked XOR cipher and serial ciphertext output.
// Define CIPHER_DEBUG_EN to append a 24-bit {key, op_cnt, err_cnt} frame after each ciphertext.
//
// state     | meaning
// IDLE      | waiting for key_load / msg_load
// LOAD_KEY  | shifting key bits into the key staging register
// LOAD_MSG  | shifting message bits into the message register
// ENCRYPT   | one cycle: sample key_sel, XOR message, start output
// SHIFT_OUT | ciphertext on ser_out, MSB first
// DEBUG_OUT | debug frame on dbg_out, MSB first (CIPHER_DEBUG_EN only)
module cipher_seq_ctrl #(
   parameter int MSG_SIZE = 64,
   parameter int KEY_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ser_in,
   input  logic       key_load,
   input  logic       msg_load,
   input  logic [1:0] key_sel,
   output logic       ser_out,
   output logic       out_valid,
   output logic       busy,
   output logic       dbg_out,
   output logic       dbg_valid
);

   localparam int CNT_W   = $clog2(MSG_SIZE + 32);
   localparam int N_CHUNK = MSG_SIZE / KEY_SIZE;

   typedef enum logic [2:0] {
      IDLE, LOAD_KEY, LOAD_MSG, ENCRYPT, SHIFT_OUT, DEBUG_OUT
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [KEY_SIZE-1:0] key_q, key_d;
   logic [KEY_SIZE-1:0] key_sr_q, key_sr_d;
   logic [MSG_SIZE-1:0] msg_q, msg_d;
   logic [7:0]          op_cnt_q, op_cnt_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic                ser_out_d, out_valid_d, busy_d;
   logic                err_inc;
   logic [KEY_SIZE-1:0] key_eff;
   logic [MSG_SIZE-1:0] cipher;

`ifdef CIPHER_DEBUG_EN
   logic [KEY_SIZE-1:0] key_applied_q, key_applied_d;
   logic [23:0]         dbg_sr_q, dbg_sr_d;
   logic                dbg_out_q, dbg_out_d;
   logic                dbg_valid_q, dbg_valid_d;
   logic [23:0]         frame;

   assign frame = {8'(key_applied_q), op_cnt_q, err_cnt_q};
`endif

   always_comb begin
      key_eff = '0;
      unique case (key_sel)
         2'b00:   key_eff = key_q;
         2'b01:   key_eff = KEY_SIZE'(8'hAC);
         2'b10:   key_eff = KEY_SIZE'(8'hCC);
         default: key_eff = '0;
      endcase
   end

   assign cipher = msg_q ^ {N_CHUNK{key_eff}};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      key_sr_d    = key_sr_q;
      msg_d       = msg_q;
      op_cnt_d    = op_cnt_q;
      err_cnt_d   = err_cnt_q;
      ser_out_d   = 1'b0;
      out_valid_d = 1'b0;
      err_inc     = 1'b0;
`ifdef CIPHER_DEBUG_EN
      key_applied_d = key_applied_q;
      dbg_sr_d      = dbg_sr_q;
      dbg_out_d     = 1'b0;
      dbg_valid_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (key_load) begin
               key_sr_d = {key_sr_q[KEY_SIZE-2:0], ser_in};
               cnt_d    = CNT_W'(KEY_SIZE - 1);
               state_d  = LOAD_KEY;
            end else if (msg_load) begin
               msg_d   = {msg_q[MSG_SIZE-2:0], ser_in};
               cnt_d   = CNT_W'(MSG_SIZE - 1);
               state_d = LOAD_MSG;
            end
         end
         LOAD_KEY: begin
            if (key_load) begin
               key_sr_d = {key_sr_q[KEY_SIZE-2:0], ser_in};
               if (cnt_q == CNT_W'(1)) begin
                  key_d   = {key_sr_q[KEY_SIZE-2:0], ser_in};
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               err_inc = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         LOAD_MSG: begin
            if (msg_load) begin
               msg_d = {msg_q[MSG_SIZE-2:0], ser_in};
               if (cnt_q == CNT_W'(1)) begin
                  cnt_d   = '0;
                  state_d = ENCRYPT;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               // partial message is simply overwritten by the next load
               err_inc = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         ENCRYPT: begin
            ser_out_d   = cipher[MSG_SIZE-1];
            out_valid_d = 1'b1;
            msg_d       = {cipher[MSG_SIZE-2:0], 1'b0};
            cnt_d       = CNT_W'(MSG_SIZE - 1);
            op_cnt_d    = op_cnt_q + 8'd1;
`ifdef CIPHER_DEBUG_EN
            key_applied_d = key_eff;
`endif
            state_d     = SHIFT_OUT;
         end
         SHIFT_OUT: begin
            if (cnt_q == '0) begin
`ifdef CIPHER_DEBUG_EN
               dbg_out_d   = frame[23];
               dbg_sr_d    = {frame[22:0], 1'b0};
               dbg_valid_d = 1'b1;
               cnt_d       = CNT_W'(23);
               state_d     = DEBUG_OUT;
`else
               state_d     = IDLE;
`endif
            end else begin
               ser_out_d   = msg_q[MSG_SIZE-1];
               out_valid_d = 1'b1;
               msg_d       = {msg_q[MSG_SIZE-2:0], 1'b0};
               cnt_d       = cnt_q - CNT_W'(1);
            end
         end
         DEBUG_OUT: begin
`ifdef CIPHER_DEBUG_EN
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               dbg_out_d   = dbg_sr_q[23];
               dbg_sr_d    = {dbg_sr_q[22:0], 1'b0};
               dbg_valid_d = 1'b1;
               cnt_d       = cnt_q - CNT_W'(1);
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase

      if (err_inc && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;

      busy_d = (state_d == ENCRYPT) || (state_d == SHIFT_OUT) || (state_d == DEBUG_OUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         key_q     <= '0;
         key_sr_q  <= '0;
         msg_q     <= '0;
         op_cnt_q  <= '0;
         err_cnt_q <= '0;
         ser_out   <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         key_q     <= key_d;
         key_sr_q  <= key_sr_d;
         msg_q     <= msg_d;
         op_cnt_q  <= op_cnt_d;
         err_cnt_q <= err_cnt_d;
         ser_out   <= ser_out_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;
      end
   end

`ifdef CIPHER_DEBUG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_applied_q <= '0;
         dbg_sr_q      <= '0;
         dbg_out_q     <= 1'b0;
         dbg_valid_q   <= 1'b0;
      end else begin
         key_applied_q <= key_applied_d;
         dbg_sr_q      <= dbg_sr_d;
         dbg_out_q     <= dbg_out_d;
         dbg_valid_q   <= dbg_valid_d;
      end
   end

   assign dbg_out   = dbg_out_q;
   assign dbg_valid = dbg_valid_q;
`else
   assign dbg_out   = 1'b0;
   assign dbg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Scoreboard bench for cipher_seq_ctrl: directed loads, expected ciphertexts queued, monitor compares bursts.
module tb_cipher_seq_ctrl;

   localparam logic [63:0] MSG   = 64'hA3B1F9D2E7C6A594;
   localparam logic [63:0] C_K00 = 64'h06145C7742630031;
   localparam logic [63:0] C_K01 = 64'h0F1D557E4B6A0938;
   localparam logic [63:0] C_K10 = 64'h6F7D351E2B0A6958;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ser_in = 1'b0;
   logic       key_load = 1'b0;
   logic       msg_load = 1'b0;
   logic [1:0] key_sel = 2'b00;
   logic       ser_out, out_valid, busy, dbg_out, dbg_valid;

   int vectors = 0;
   int miscompares = 0;
   int bursts = 0;

   logic [63:0] exp_q[$];
   logic [23:0] dbg_q[$];

   cipher_seq_ctrl #(.MSG_SIZE(64), .KEY_SIZE(8)) dut (
      .clk(clk), .rst(rst), .ser_in(ser_in), .key_load(key_load), .msg_load(msg_load),
      .key_sel(key_sel), .ser_out(ser_out), .out_valid(out_valid), .busy(busy),
      .dbg_out(dbg_out), .dbg_valid(dbg_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ciphertext monitor
   logic [63:0] acc = '0;
   int          nb = 0;
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst) begin
         nb = 0;
      end else if (out_valid) begin
         acc = {acc[62:0], ser_out};
         nb++;
      end else if (nb > 0) begin
         bursts++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_burst: got %h (%0d bits) expected none", acc, nb);
         end else begin
            e = exp_q.pop_front();
            if (acc !== e || nb != 64) begin
               miscompares++;
               $display("FAIL ciphertext: got %h (%0d bits) expected %h (64 bits)", acc, nb, e);
            end
         end
         nb = 0;
      end
   end

`ifdef CIPHER_DEBUG_EN
   logic [23:0] dacc = '0;
   int          dn = 0;
   always @(negedge clk) begin
      logic [23:0] e;
      if (rst) begin
         dn = 0;
      end else if (dbg_valid) begin
         dacc = {dacc[22:0], dbg_out};
         dn++;
      end else if (dn > 0) begin
         vectors++;
         if (dbg_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_dbg: got %h (%0d bits) expected none", dacc, dn);
         end else begin
            e = dbg_q.pop_front();
            if (dacc !== e || dn != 24) begin
               miscompares++;
               $display("FAIL dbg_frame: got %h (%0d bits) expected %h (24 bits)", dacc, dn, e);
            end
         end
         dn = 0;
      end
   end
`endif

   task automatic load_key(input logic [7:0] k);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         key_load = 1'b1;
         ser_in   = k[i];
      end
      @(negedge clk);
      key_load = 1'b0;
      ser_in   = 1'b0;
   endtask

   task automatic load_msg(input logic [63:0] m, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         msg_load = 1'b1;
         ser_in   = m[63-i];
      end
      @(negedge clk);
      msg_load = 1'b0;
      ser_in   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic encrypt(input logic [1:0] sel, input logic [63:0] exp_c, input logic [23:0] exp_f,
                          input string name);
      key_sel = sel;
      exp_q.push_back(exp_c);
`ifdef CIPHER_DEBUG_EN
      dbg_q.push_back(exp_f);
`endif
      load_msg(MSG, 64);
      wait_idle(name);
   endtask

   initial begin
      int n;
      int b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ser_out",   64'(ser_out),   64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_dbg_valid", 64'(dbg_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      load_key(8'hA5);
      encrypt(2'b00, C_K00, 24'hA50100, "key00");
      encrypt(2'b01, C_K01, 24'hAC0200, "key01");
      encrypt(2'b10, C_K10, 24'hCC0300, "key10");
      encrypt(2'b11, MSG,   24'h000400, "key11");

      // partial message: no output, one error, then a clean encryption
      key_sel = 2'b00;
      b0 = bursts;
      load_msg(MSG, 20);
      repeat (5) @(negedge clk);
      chk("partial_busy", 64'(busy), 64'd0);
      chk("partial_err_cnt", 64'(dut.err_cnt_q), 64'd1);
      repeat (80) @(negedge clk);
      chk("partial_no_burst", 64'(bursts), 64'(b0));
      encrypt(2'b00, C_K00, 24'hA50501, "after_partial");

      // key_load during SHIFT_OUT is ignored
      exp_q.push_back(C_K00);
`ifdef CIPHER_DEBUG_EN
      dbg_q.push_back(24'hA50601);
`endif
      load_msg(MSG, 64);
      repeat (10) @(negedge clk);
      chk("shift_busy", 64'(busy), 64'd1);
      load_key(8'hFF);
      wait_idle("keyload_during_shift");
      chk("ignored_err_cnt", 64'(dut.err_cnt_q), 64'd1);
      encrypt(2'b00, C_K00, 24'hA50701, "key_unchanged");

      // reset in the middle of the ciphertext
      load_msg(MSG, 64);
      n = 0;
      while (n < 30 && vectors < 100000) begin
         @(negedge clk);
         if (out_valid) n++;
         if (n == 0 && !busy) break;
      end
      chk("reached_bit30", 64'(n), 64'd30);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_ser_out",   64'(ser_out),   64'd0);
      chk("midrst_busy",      64'(busy),      64'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      chk("midrst_err_cnt", 64'(dut.err_cnt_q), 64'd0);
      encrypt(2'b00, MSG, 24'h000100, "post_rst_key0");

      repeat (5) @(negedge clk);
      chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef CIPHER_DEBUG_EN
      chk("dbg_queue_drained", 64'(dbg_q.size()), 64'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "timeout");
   end

endmodule
